// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and helpers for the PC / fetch-control stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

    // Keeps only the word-address bits that exist in an instruction memory
    // of mem_words words; bits [1:0] are always cleared.
    function automatic logic [31:0] pc_mask(input int unsigned mem_words);
        int unsigned bits;
        logic [31:0] m;
        bits = $clog2(mem_words) + 2;
        if (bits >= 32)
            m = 32'hFFFF_FFFF;
        else
            m = (32'd1 << bits) - 32'd1;
        return m & ~32'd3;
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/next_pc_sel.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_sel
// Description : Priority mux for the next PC plus address-space masking.
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_sel
    import fetch_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    input  logic        hold,
    input  logic        pc_load,
    input  logic [31:0] load_addr,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    output logic [31:0] next_pc
);

    localparam logic [31:0] PC_MASK = pc_mask(MEM_WORDS);

    logic [31:0] w_raw_pc;

    // hold covers stall, halt detection and the non-RUN states; only a
    // load may override it.
    always_comb begin
        w_raw_pc = pc_plus4;
        if (pc_load)
            w_raw_pc = load_addr;
        else if (hold)
            w_raw_pc = pc;
        else if (jump)
            w_raw_pc = {pc_plus4[31:28], jump_target, 2'b00};
        else if (branch_taken)
            w_raw_pc = pc_plus4 + (branch_offset << 2);
        next_pc = w_raw_pc & PC_MASK;
    end

endmodule : next_pc_sel
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : PC register, run/halt FSM, fetch counter and alignment flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned MEM_WORDS  = 256,
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        pc_load,
    input  logic [31:0] load_addr,
    input  logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        halted,
    output logic        misaligned_err,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] PC_MASK = pc_mask(MEM_WORDS);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_fetch_count;
    logic         r_misaligned;

    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_next_pc;
    logic         w_valid;
    logic         w_halt_hit;
    logic         w_hold;

    assign w_pc_plus4 = (r_pc + 32'd4) & PC_MASK;
    assign w_valid    = (r_state == ST_RUN) && !stall;
    assign w_halt_hit = w_valid && (instruction == HALT_INSTR);
    assign w_hold     = (r_state != ST_RUN) || stall || w_halt_hit;

    next_pc_sel #(
        .MEM_WORDS (MEM_WORDS)
    ) u_next_pc_sel (
        .pc            (r_pc),
        .pc_plus4      (w_pc_plus4),
        .hold          (w_hold),
        .pc_load       (pc_load),
        .load_addr     (load_addr),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .next_pc       (w_next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_INIT;
            r_pc          <= RESET_PC;
            r_fetch_count <= 32'd0;
            r_misaligned  <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            if (w_valid)
                r_fetch_count <= r_fetch_count + 32'd1;
            if (pc_load && (load_addr[1:0] != 2'b00))
                r_misaligned <= 1'b1;
            case (r_state)
                ST_INIT: r_state <= ST_RUN;
                ST_RUN: begin
                    // A simultaneous load outranks halt detection.
                    if (!pc_load && w_halt_hit)
                        r_state <= ST_HALT;
                end
                ST_HALT: begin
                    if (pc_load)
                        r_state <= ST_RUN;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign pc             = r_pc;
    assign pc_plus4       = w_pc_plus4;
    assign instr_valid    = w_valid;
    assign instr_out      = w_valid ? instruction : 32'd0;
    assign halted         = (r_state == ST_HALT);
    assign misaligned_err = r_misaligned;
    assign fetch_count    = r_fetch_count;

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Table-driven self-checking bench for pc_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        pc_load;
    logic [31:0] load_addr;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        halted;
    logic        misaligned_err;
    logic [31:0] fetch_count;
    logic        force_halt;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_offset  (branch_offset),
        .jump           (jump),
        .jump_target    (jump_target),
        .pc_load        (pc_load),
        .load_addr      (load_addr),
        .instruction    (instruction),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .halted         (halted),
        .misaligned_err (misaligned_err),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: a recognisable word per address, or the halt encoding.
    assign instruction = force_halt ? 32'hFFFF_FFFF : (32'hA500_0000 | pc);

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] off;
        logic        jmp;
        logic [25:0] tgt;
        logic        ld;
        logic [31:0] laddr;
        logic        hlt;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_halted;
        logic [31:0] exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t vecs[32];

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] o,
                                input logic j, input logic [25:0] t, input logic l,
                                input logic [31:0] a, input logic h, input logic ev,
                                input logic [31:0] ep, input logic eh,
                                input logic [31:0] ec, input logic ee);
        vec_t v;
        v.stall = s; v.br = b; v.off = o; v.jmp = j; v.tgt = t; v.ld = l;
        v.laddr = a; v.hlt = h; v.exp_valid = ev; v.exp_pc = ep;
        v.exp_halted = eh; v.exp_cnt = ec; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; branch_taken = 0; branch_offset = 0; jump = 0;
        jump_target = 0; pc_load = 0; load_addr = 0; force_halt = 0;
    endtask

    logic [31:0] cur_pc;
    logic [31:0] exp_instr;

    initial begin
        //             st br off            jmp tgt         ld laddr          hlt  val pc          h  cnt err
        vecs[0]  = mk(0, 0, 32'd0,          0, 26'd0,       0, 32'd0,          0,  0, 32'h000,  0, 0,  0);
        vecs[1]  = mk(0, 0, 32'd0,          0, 26'd0,       0, 32'd0,          0,  1, 32'h004,  0, 1,  0);
        vecs[2]  = mk(0, 0, 32'd0,          0, 26'd0,       0, 32'd0,          0,  1, 32'h008,  0, 2,  0);
        vecs[3]  = mk(0, 0, 32'd0,          0, 26'd0,       0, 32'd0,          0,  1, 32'h00C,  0, 3,  0);
        vecs[4]  = mk(0, 0, 32'd0,          0, 26'd0,       0, 32'd0,          0,  1, 32'h010,  0, 4,  0);
        vecs[5]  = mk(0, 1, 32'hFFFF_FFFE,  0, 26'd0,       0, 32'd0,          0,  1, 32'h00C,  0, 5,  0);
        vecs[6]  = mk(0, 0, 32'd0,          0, 26'd0,       1, 32'h20,         0,  1, 32'h020,  0, 6,  0);
        vecs[7]  = mk(0, 1, 32'd5,          1, 26'h40,      0, 32'd0,          0,  1, 32'h100,  0, 7,  0);
        vecs[8]  = mk(0, 0, 32'd0,          0, 26'd0,       1, 32'h3F8,        0,  1, 32'h3F8,  0, 8,  0);
        vecs[9]  = mk(0, 0, 32'd0,          0, 26'd0,       0, 32'd0,          0,  1, 32'h3FC,  0, 9,  0);
        vecs[10] = mk(0, 0, 32'd0,          0, 26'd0,       0, 32'd0,          0,  1, 32'h000,  0, 10, 0);
        vecs[11] = mk(0, 0, 32'd0,          0, 26'd0,       0, 32'd0,          0,  1, 32'h004,  0, 11, 0);
        vecs[12] = mk(0, 0, 32'd0,          0, 26'd0,       0, 32'd0,          0,  1, 32'h008,  0, 12, 0);
        vecs[13] = mk(1, 0, 32'd0,          0, 26'd0,       0, 32'd0,          0,  0, 32'h008,  0, 12, 0);
        vecs[14] = mk(1, 0, 32'd0,          0, 26'd0,       0, 32'd0,          0,  0, 32'h008,  0, 12, 0);
        vecs[15] = mk(1, 0, 32'd0,          0, 26'd0,       0, 32'd0,          0,  0, 32'h008,  0, 12, 0);
        vecs[16] = mk(1, 0, 32'd0,          0, 26'd0,       1, 32'h40,         0,  0, 32'h040,  0, 12, 0);
        vecs[17] = mk(0, 0, 32'd0,          0, 26'd0,       1, 32'h08,         0,  1, 32'h008,  0, 13, 0);
        vecs[18] = mk(0, 0, 32'd0,          0, 26'd0,       0, 32'd0,          0,  1, 32'h00C,  0, 14, 0);
        vecs[19] = mk(0, 0, 32'd0,          0, 26'd0,       0, 32'd0,          1,  1, 32'h00C,  1, 15, 0);
        vecs[20] = mk(0, 0, 32'd0,          1, 26'h40,      0, 32'd0,          0,  0, 32'h00C,  1, 15, 0);
        vecs[21] = mk(1, 1, 32'd3,          0, 26'd0,       0, 32'd0,          0,  0, 32'h00C,  1, 15, 0);
        vecs[22] = mk(0, 0, 32'd0,          0, 26'd0,       1, 32'h00,         0,  0, 32'h000,  0, 15, 0);
        vecs[23] = mk(0, 0, 32'd0,          0, 26'd0,       0, 32'd0,          0,  1, 32'h004,  0, 16, 0);
        vecs[24] = mk(0, 0, 32'd0,          0, 26'd0,       1, 32'h06,         0,  1, 32'h004,  0, 17, 1);
        vecs[25] = mk(0, 0, 32'd0,          0, 26'd0,       0, 32'd0,          0,  1, 32'h008,  0, 18, 1);
        vecs[26] = mk(0, 0, 32'd0,          0, 26'd0,       0, 32'd0,          0,  1, 32'h00C,  0, 19, 1);
        vecs[27] = mk(0, 0, 32'd0,          1, 26'h3FF_FFFF,0, 32'd0,          0,  1, 32'h3FC,  0, 20, 1);
        vecs[28] = mk(0, 1, 32'd1,          0, 26'd0,       0, 32'd0,          0,  1, 32'h004,  0, 21, 1);
        vecs[29] = mk(0, 0, 32'd0,          0, 26'd0,       1, 32'hFFFF_F010,  0,  1, 32'h010,  0, 22, 1);
        vecs[30] = mk(1, 0, 32'd0,          0, 26'd0,       0, 32'd0,          1,  0, 32'h010,  0, 22, 1);
        vecs[31] = mk(0, 0, 32'd0,          0, 26'd0,       1, 32'h20,         1,  1, 32'h020,  0, 23, 1);

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset pc", pc, 32'h0);
        chk("reset pc_plus4", pc_plus4, 32'h4);
        chk("reset instr_out", instr_out, 32'h0);
        chk("reset instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("reset halted", {31'd0, halted}, 32'd0);
        chk("reset misaligned_err", {31'd0, misaligned_err}, 32'd0);
        chk("reset fetch_count", fetch_count, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        cur_pc = 32'h0;
        for (int i = 0; i < 32; i++) begin
            stall = vecs[i].stall; branch_taken = vecs[i].br;
            branch_offset = vecs[i].off; jump = vecs[i].jmp;
            jump_target = vecs[i].tgt; pc_load = vecs[i].ld;
            load_addr = vecs[i].laddr; force_halt = vecs[i].hlt;
            #1;
            exp_instr = vecs[i].hlt ? 32'hFFFF_FFFF : (32'hA500_0000 | cur_pc);
            chk($sformatf("v%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("v%0d instr_out", i), instr_out, vecs[i].exp_valid ? exp_instr : 32'd0);
            chk($sformatf("v%0d pc_plus4", i), pc_plus4, (cur_pc + 32'd4) & 32'h3FC);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("v%0d halted", i), {31'd0, halted}, {31'd0, vecs[i].exp_halted});
            chk($sformatf("v%0d fetch_count", i), fetch_count, vecs[i].exp_cnt);
            chk($sformatf("v%0d misaligned_err", i), {31'd0, misaligned_err}, {31'd0, vecs[i].exp_err});
            cur_pc = vecs[i].exp_pc;
            @(negedge clk);
        end

        // Asynchronous reset mid-cycle, then a load accepted while in INIT.
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst pc", pc, 32'h0);
        chk("midrst fetch_count", fetch_count, 32'd0);
        chk("midrst misaligned_err", {31'd0, misaligned_err}, 32'd0);
        chk("midrst instr_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pc_load = 1'b1;
        load_addr = 32'h80;
        #1;
        chk("init instr_valid", {31'd0, instr_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("init load pc", pc, 32'h80);
        @(negedge clk);
        pc_load = 1'b0;
        #1;
        chk("after init valid", {31'd0, instr_valid}, 32'd1);
        chk("after init instr_out", instr_out, 32'hA500_0080);
        @(posedge clk);
        #1;
        chk("after init pc", pc, 32'h84);
        chk("after init fetch_count", fetch_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected end by 100000");
        $fatal(1);
    end

endmodule : tb_pc_fetch_unit
`default_nettype wire

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and fetch-control stage that sits directly upstream of the 32x256 instruction memory. It drives the byte address into the memory, accepts the returned instruction in the same cycle, and computes the next PC from sequential, branch, jump and load requests. It also tracks run/halt state and counts retired fetches. The combinational memory produces the instruction word from `pc`, and this block forwards it to decode with a valid qualifier.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset; must be word-aligned.
- `MEM_WORDS`, default 256: instruction memory depth in words; power of two.
- `HALT_INSTR`, default 32'hFFFF_FFFF: instruction encoding that stops fetch.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  freeze PC, state and counter this cycle.
- `branch_taken`  in  1  take the PC-relative branch.
- `branch_offset`  in  32  signed word offset, already sign-extended.
- `jump`  in  1  take the absolute jump.
- `jump_target`  in  26  word index field of the jump.
- `pc_load`  in  1  force-load the PC; also restarts from HALT.
- `load_addr`  in  32  byte address for `pc_load`.
- `instruction`  in  32  word returned by instruction memory for `pc`.
- `pc`  out  32  current byte address; drives the memory address port.
- `pc_plus4`  out  32  `pc + 4`, wrapped; provided for link and writeback.
- `instr_out`  out  32  `instruction` passed through; forced to 0 unless valid.
- `instr_valid`  out  1  `instr_out` is a fetch to execute this cycle.
- `halted`  out  1  block is in the HALT state.
- `misaligned_err`  out  1  sticky: a `pc_load` address had nonzero bits [1:0].
- `fetch_count`  out  32  number of valid fetches; wraps modulo 2^32.

## Operation
- Address space is `MEM_WORDS*4` bytes (1024 by default).
  - All computed PCs are masked to `log2(MEM_WORDS)+2` bits, with bits [1:0] forced to 0.
  - Upper bits are 0, so the PC wraps around: 0x3FC + 4 gives 0x000.
- States:
  - INIT: first cycle after reset is released. `instr_valid`=0. Transitions to RUN unconditionally; `pc` holds `RESET_PC`.
  - RUN: `instr_valid = !stall`.
  - HALT: `instr_valid`=0, `pc` frozen.
- Next-PC priority, in RUN:
  - `pc_load` > `stall` > halt detect > `jump` > `branch_taken` > sequential.
  - load: `pc = load_addr` with bits [1:0] cleared and masked; if `load_addr[1:0] != 0`, set `misaligned_err`.
  - jump: `{pc_plus4[31:28], jump_target, 2'b00}`, then masked.
  - branch: `pc_plus4 + (branch_offset << 2)`, 32-bit wrap, then masked.
  - sequential: `pc_plus4`.
- Halt detect: in RUN, with `!stall` and `instruction == HALT_INSTR`:
  - `instr_valid`=1 for that cycle and the counter increments.
  - Next state is HALT and `pc` does not advance.
- In HALT only `pc_load` has effect: it loads the PC and returns the block to RUN. `stall`, `jump` and `branch_taken` are ignored.
- In INIT, `pc_load` is honoured and the block still moves to RUN.
- `fetch_count` increments on every cycle with `instr_valid`=1.
- `misaligned_err` clears only on reset.

## Timing
- Reset values:
  - `pc = RESET_PC`, `pc_plus4 = RESET_PC + 4`.
  - `instr_out = 0`, `instr_valid = 0`, `halted = 0`, `misaligned_err = 0`, `fetch_count = 0`.
  - State = INIT.
- Reset applies immediately on `rst_n` falling, mid-operation included. No partial update is allowed.
- Address-to-instruction path is combinational: `pc`, then memory, then `instr_out` within the same cycle.
- Redirects (`jump`, `branch_taken`, `pc_load`) take effect on `pc` one edge after they are sampled. There are no delay slots.
- `stall` held N cycles: `pc` and `fetch_count` are unchanged for N edges and `instr_valid`=0 for those N cycles.
- `halted` asserts the cycle after the halting fetch and deasserts the cycle after `pc_load`.

## Structure
- Shared package `fetch_pkg`: the state enum (INIT/RUN/HALT), `HALT_INSTR` default, and the `PC_MASK` derivation function.
- One sub-module, `next_pc_sel`: combinational priority mux plus address masking. The top level holds the PC register, the FSM, the counter and the sticky error flag.

## Test plan
- Reset, then run 4 cycles with no requests:
  - `pc` goes 0 → 0 → 4 → 8 → 12 (INIT holds 0 for the first cycle).
  - `fetch_count`=3.
  - Pulse `rst_n` low mid-run: `pc`=0 immediately and `fetch_count`=0.
- Wrap: `pc_load` with 0x3F8, then free run. `pc` goes 0x3F8 → 0x3FC → 0x000.
- Branch and jump:
  - At `pc`=0x10, `branch_taken`=1 with `branch_offset`=-2: next `pc`=0x0C.
  - At `pc`=0x20, `jump`=1 and `branch_taken`=1 with `jump_target`=0x40: next `pc`=0x100, because jump wins.
- Stall: assert `stall` for 3 cycles at `pc`=0x08.
  - `pc` holds 0x08 and `instr_valid`=0 for those cycles.
  - Simultaneous `pc_load` with 0x40 during the stall: `pc`=0x40, since load wins over stall.
- Halt: memory returns 0xFFFFFFFF at `pc`=0x0C.
  - That cycle has `instr_valid`=1; from the next cycle `halted`=1 and `pc` stays 0x0C.
  - `jump` is ignored in HALT.
  - `pc_load` with 0x00 gives `halted`=0 and `pc`=0 on the next cycle.
- Misaligned load: `pc_load` with 0x06 gives `pc`=0x04 and `misaligned_err`=1. The flag stays set through later fetches until reset.
